fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), is the instruction word loaded into IF/ID for a bubble.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall_d  input  1  hold the IF/ID register.
REQ-006 flush_d  input  1  load a bubble into IF/ID.
REQ-007 pcsrc_e  input  1  taken branch/jump redirect from EX.
REQ-008 pctarget_e  input  32  redirect target address.
REQ-009 imem_req  output  1  instruction memory request.
REQ-010 imem_addr  output  32  request address, word aligned.
REQ-011 imem_valid  input  1  response valid; may assert in the request cycle (zero wait) or later.
REQ-012 imem_rdata  input  32  instruction word, meaningful only when imem_valid=1.
REQ-013 instr_d  output  32  IF/ID instruction; bits [31:7] drive the immediate extender.
REQ-014 pc_d  output  32  IF/ID PC.
REQ-015 pcplus4_d  output  32  IF/ID PC+4, modulo 2^32.
REQ-016 valid_d  output  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states: REQ (request outstanding), DRAIN (discard outstanding response, then redirect), HOLD (hold buffer full, no request).
REQ-018 In REQ and DRAIN, imem_req=1; in HOLD, imem_req=0. imem_addr stays stable from request until imem_valid=1.
REQ-019 REQ with imem_valid=1 and no redirect: the response is accepted and fetch_pc advances by 4 (wrapping at 2^32); the next request issues the following cycle.
REQ-020 Accepted response with stall_d=0 loads IF/ID {imem_rdata, fetch_pc, fetch_pc+4, valid=1}; the FSM stays in REQ.
REQ-021 Accepted response with stall_d=1 goes to a one-entry hold buffer; the FSM enters HOLD.
REQ-022 HOLD with stall_d=0: the hold buffer loads IF/ID, the buffer empties, and the FSM returns to REQ in the same cycle.
REQ-023 Cycle with stall_d=0, flush_d=0, no redirect, and no instruction available: IF/ID loads a bubble {NOP_INSTR, valid=0}; pc_d and pcplus4_d hold.
REQ-024 flush_d=1 or pcsrc_e=1 loads a bubble into IF/ID; this has priority over stall_d and over any same-cycle response.
REQ-025 pcsrc_e=1 in REQ with imem_valid=1, or in HOLD: discard the response/buffer; fetch_pc=pctarget_e; FSM to REQ.
REQ-026 pcsrc_e=1 in REQ with imem_valid=0: latch pctarget_e as the pending target; FSM to DRAIN.
REQ-027 DRAIN: responses are discarded. On imem_valid=1, fetch_pc=pending target and the FSM goes to REQ. A new pcsrc_e in DRAIN overwrites the pending target; the newer target wins.
REQ-028 pctarget_e[1:0] are ignored (forced to 0).

Reset
REQ-029 While reset_n=0: state=REQ, fetch_pc=RESET_PC, hold buffer empty, instr_d=NOP_INSTR, pc_d=0, pcplus4_d=0, valid_d=0. The request to RESET_PC is visible in the first cycle after release.
REQ-030 Reset asserted mid-operation abandons any outstanding request; the memory side must tolerate a dropped response.

Structure
REQ-031 Shared pipeline package holds the FSM state enum, NOP_INSTR, and a struct {instr, pc, pcplus4, valid} used for IF/ID and the hold buffer.
REQ-032 One sub-module, if_id_reg, implements the IF/ID register with enable and bubble-clear; the FSM and fetch_pc live in fetch_stage.

Verification
REQ-033 Reset release, RESET_PC=0, zero-wait, rdata 0x00500093 -> next cycle instr_d=0x00500093, pc_d=0, pcplus4_d=4, valid_d=1, imem_addr=4.
REQ-034 Request at 0x8, imem_valid low for 3 cycles -> imem_addr=0x8 throughout; valid_d=0 and instr_d=0x00000013 for 3 cycles; pc_d is not updated during these cycles.
REQ-035 pcsrc_e=1, pctarget_e=0x100, with zero-wait response at 0xC -> that response discarded, IF/ID bubble, next imem_addr=0x100.
REQ-036 pcsrc_e=1 (target 0x200) while 0x10 is waiting; valid after 2 more cycles -> data dropped, then imem_addr=0x200, no valid_d for 0x10.
REQ-037 stall_d=1 for 2 cycles when 0x14 returns -> imem_req=0 and IF/ID unchanged for 2 cycles; after release, pc_d=0x14, then imem_addr=0x18.
REQ-038 stall_d=1 and flush_d=1 together -> bubble (valid_d=0, instr_d=0x00000013); a pending hold buffer is retained.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, the default bubble word and the
// IF/ID payload layout used by both the pipeline register and the hold buffer.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: a bubble clears the instruction and valid bit but
// keeps the PC fields, so a bubble never disturbs pc_d/pcplus4_d.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  en,
    input  logic  clear,
    input  ifid_t d,
    output ifid_t q
);

    // Clear wins over enable so a flush can never be overridden by a load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.instr   <= NOP_INSTR;
            q.pc      <= '0;
            q.pcplus4 <= '0;
            q.valid   <= 1'b0;
        end else if (clear) begin
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives a variable-latency instruction memory,
// handles EX redirects (including ones that arrive while a request is in
// flight) and buffers one instruction while decode is stalled.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pcsrc_e,
    input  logic [31:0] pctarget_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d
);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  pending_target, pending_target_next;
    ifid_t        hold_buf, hold_buf_next;

    logic         ifid_en;
    logic         ifid_clear;
    ifid_t        ifid_d;
    ifid_t        ifid_q;

    logic [31:0]  target;
    logic         take;
    ifid_t        fetched;

    assign target  = word_align(pctarget_e);
    // Flush blocks a transfer into IF/ID; only a redirect discards a fetch.
    assign take    = !stall_d && !flush_d;
    assign fetched = '{instr: imem_rdata, pc: fetch_pc, pcplus4: fetch_pc + 32'd4, valid: 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_REQ;
            fetch_pc       <= word_align(RESET_PC);
            pending_target <= '0;
            hold_buf       <= '0;
        end else begin
            state          <= state_next;
            fetch_pc       <= fetch_pc_next;
            pending_target <= pending_target_next;
            hold_buf       <= hold_buf_next;
        end
    end

    always_comb begin
        state_next          = state;
        fetch_pc_next       = fetch_pc;
        pending_target_next = pending_target;
        hold_buf_next       = hold_buf;
        ifid_en             = 1'b0;
        ifid_clear          = 1'b0;
        ifid_d              = hold_buf;
        imem_req            = 1'b1;

        case (state)
            ST_REQ: begin
                if (pcsrc_e) begin
                    ifid_clear = 1'b1;
                    if (imem_valid) begin
                        fetch_pc_next = target;
                    end else begin
                        pending_target_next = target;
                        state_next          = ST_DRAIN;
                    end
                end else if (imem_valid) begin
                    fetch_pc_next = fetch_pc + 32'd4;
                    if (take) begin
                        ifid_en = 1'b1;
                        ifid_d  = fetched;
                    end else begin
                        hold_buf_next = fetched;
                        state_next    = ST_HOLD;
                        ifid_clear    = flush_d;
                    end
                end else begin
                    ifid_clear = flush_d || !stall_d;
                end
            end

            // The in-flight response belongs to the abandoned path; wait for it.
            ST_DRAIN: begin
                ifid_clear = pcsrc_e || flush_d || !stall_d;
                if (pcsrc_e) begin
                    pending_target_next = target;
                end
                if (imem_valid) begin
                    fetch_pc_next = pcsrc_e ? target : pending_target;
                    state_next    = ST_REQ;
                end
            end

            ST_HOLD: begin
                imem_req = 1'b0;
                if (pcsrc_e) begin
                    ifid_clear          = 1'b1;
                    hold_buf_next.valid = 1'b0;
                    fetch_pc_next       = target;
                    state_next          = ST_REQ;
                end else if (take) begin
                    ifid_en             = 1'b1;
                    hold_buf_next.valid = 1'b0;
                    state_next          = ST_REQ;
                end else begin
                    ifid_clear = flush_d;
                end
            end

            default: begin
                state_next = ST_REQ;
            end
        endcase
    end

    assign imem_addr = fetch_pc;

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (ifid_en),
        .clear  (ifid_clear),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign instr_d   = ifid_q.instr;
    assign pc_d      = ifid_q.pc;
    assign pcplus4_d = ifid_q.pcplus4;
    assign valid_d   = ifid_q.valid;

endmodule
